// File: rtl/sdio_host_data_phy.sv
// sdio_host_data_phy: 4-bit SDR SDIO data-line engine with per-line CRC16,
// write CRC-status/busy handling and read CRC checking.
module sdio_host_data_phy #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_activate,
    input  logic        i_write_flag,
    input  logic [12:0] i_data_count,
    input  logic [7:0]  i_wr_data,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    output logic [7:0]  o_rd_data,
    output logic        o_rd_stb,
    output logic        o_finished,
    output logic        o_crc_err,
    output logic        o_timeout,
    output logic        o_underrun,
    output logic        o_busy,
    output logic        o_sdio_data_dir,
    output logic [3:0]  o_sdio_data_out,
    input  logic [3:0]  i_sdio_data_in
);
    typedef enum logic [3:0] {
        IDLE, WR_START, WR_DATA, WR_CRC, WR_END, WR_NCRC, WR_STATUS,
        WR_BUSY, RD_WAIT, RD_DATA, RD_CRC, RD_END, FINISHED
    } state_t;

    state_t            r_state;
    logic [12:0]       r_left;
    logic              r_low;
    logic [3:0]        r_cnt;
    logic [2:0]        r_bit;
    logic [2:0]        r_stat;
    logic [7:0]        r_byte;
    logic [3:0][15:0]  r_crc;
    logic              r_bad;
    logic [15:0]       r_tmo;
    logic              r_dir;
    logic [3:0]        r_out;
    logic              r_wr_ready;
    logic [7:0]        r_rd_data;
    logic              r_rd_stb;
    logic              r_finished;
    logic              r_crc_err;
    logic              r_timeout;
    logic              r_underrun;
    logic              r_busy;

    logic [3:0]        w_nib;
    logic [3:0][15:0]  w_crc_nxt;
    logic [3:0][15:0]  w_crc_shl;
    logic [3:0]        w_crc_msb;
    logic              w_tmo_hit;

    function automatic logic [15:0] f_crc(input logic [15:0] c, input logic b);
        f_crc = {c[14:0], 1'b0} ^ ({16{c[15] ^ b}} & 16'h1021);
    endfunction

    // Nibble fed to the CRCs: outgoing on writes, the bus on reads
    always_comb begin
        w_nib = i_sdio_data_in;
        if (r_state == WR_START || (r_state == WR_DATA && !r_low))
            w_nib = i_wr_data[7:4];
        else if (r_state == WR_DATA)
            w_nib = r_byte[3:0];
        for (int i = 0; i < 4; i++) begin
            w_crc_nxt[i] = f_crc(r_crc[i], w_nib[i]);
            w_crc_shl[i] = {r_crc[i][14:0], 1'b0};
            w_crc_msb[i] = r_crc[i][15];
        end
    end

    assign w_tmo_hit = (r_tmo == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_left     <= '0;
            r_low      <= 1'b0;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_stat     <= '0;
            r_byte     <= '0;
            r_crc      <= '0;
            r_bad      <= 1'b0;
            r_tmo      <= '0;
            r_dir      <= 1'b0;
            r_out      <= 4'hF;
            r_wr_ready <= 1'b0;
            r_rd_data  <= '0;
            r_rd_stb   <= 1'b0;
            r_finished <= 1'b0;
            r_crc_err  <= 1'b0;
            r_timeout  <= 1'b0;
            r_underrun <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rd_stb <= 1'b0;
            r_tmo    <= '0;
            if (!i_activate) begin
                r_state    <= IDLE;
                r_dir      <= 1'b0;
                r_out      <= 4'hF;
                r_wr_ready <= 1'b0;
                r_finished <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_crc_err  <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_underrun <= 1'b0;
                        r_crc      <= '0;
                        r_bad      <= 1'b0;
                        r_low      <= 1'b0;
                        r_left     <= i_data_count;
                        if (i_data_count == 13'd0) begin
                            r_state    <= FINISHED;
                            r_finished <= 1'b1;
                        end else if (i_write_flag) begin
                            r_state    <= WR_START;
                            r_dir      <= 1'b1;
                            r_out      <= 4'h0;
                            r_wr_ready <= 1'b1;
                        end else begin
                            r_state <= RD_WAIT;
                        end
                    end
                    WR_START, WR_DATA: begin
                        if (r_state == WR_DATA && r_low) begin
                            r_out      <= r_byte[3:0];
                            r_crc      <= w_crc_nxt;
                            r_low      <= 1'b0;
                            r_wr_ready <= (r_left != 13'd0);
                        end else if (r_left == 13'd0) begin
                            r_state <= WR_CRC;
                            r_out   <= w_crc_msb;
                            r_crc   <= w_crc_shl;
                            r_cnt   <= 4'd15;
                        end else if (i_wr_valid) begin
                            r_state    <= WR_DATA;
                            r_byte     <= i_wr_data;
                            r_out      <= i_wr_data[7:4];
                            r_crc      <= w_crc_nxt;
                            r_low      <= 1'b1;
                            r_left     <= r_left - 13'd1;
                            r_wr_ready <= 1'b0;
                        end else begin
                            r_state    <= FINISHED;
                            r_underrun <= 1'b1;
                            r_finished <= 1'b1;
                            r_dir      <= 1'b0;
                            r_out      <= 4'hF;
                            r_wr_ready <= 1'b0;
                        end
                    end
                    WR_CRC: begin
                        if (r_cnt == 4'd0) begin
                            r_state <= WR_END;
                            r_out   <= 4'hF;
                        end else begin
                            r_out <= w_crc_msb;
                            r_crc <= w_crc_shl;
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                    WR_END: begin
                        r_state <= WR_NCRC;
                        r_dir   <= 1'b0;
                        r_cnt   <= 4'd1;
                    end
                    WR_NCRC: begin
                        r_bit <= '0;
                        if (r_cnt == 4'd0) r_state <= WR_STATUS;
                        else r_cnt <= r_cnt - 4'd1;
                    end
                    WR_STATUS: begin
                        if (r_bit == 3'd0) begin
                            if (!i_sdio_data_in[0]) begin
                                r_bit <= 3'd1;
                            end else if (w_tmo_hit) begin
                                r_state    <= FINISHED;
                                r_timeout  <= 1'b1;
                                r_finished <= 1'b1;
                            end else begin
                                r_tmo <= r_tmo + 16'd1;
                            end
                        end else if (r_bit != 3'd4) begin
                            r_stat <= {r_stat[1:0], i_sdio_data_in[0]};
                            r_bit  <= r_bit + 3'd1;
                        end else if (r_stat != 3'b010 || !i_sdio_data_in[0]) begin
                            r_state    <= FINISHED;
                            r_crc_err  <= 1'b1;
                            r_finished <= 1'b1;
                        end else begin
                            r_state <= WR_BUSY;
                        end
                    end
                    WR_BUSY: begin
                        if (i_sdio_data_in[0]) begin
                            r_state    <= FINISHED;
                            r_busy     <= 1'b0;
                            r_finished <= 1'b1;
                        end else if (w_tmo_hit) begin
                            r_state    <= FINISHED;
                            r_busy     <= 1'b0;
                            r_timeout  <= 1'b1;
                            r_finished <= 1'b1;
                        end else begin
                            r_busy <= 1'b1;
                            r_tmo  <= r_tmo + 16'd1;
                        end
                    end
                    RD_WAIT: begin
                        if (i_sdio_data_in == 4'h0) begin
                            r_state <= RD_DATA;
                            r_low   <= 1'b0;
                        end else if (w_tmo_hit) begin
                            r_state    <= FINISHED;
                            r_timeout  <= 1'b1;
                            r_finished <= 1'b1;
                        end else begin
                            r_tmo <= r_tmo + 16'd1;
                        end
                    end
                    RD_DATA: begin
                        r_crc <= w_crc_nxt;
                        if (!r_low) begin
                            r_byte[7:4] <= i_sdio_data_in;
                            r_low       <= 1'b1;
                        end else begin
                            r_rd_data <= {r_byte[7:4], i_sdio_data_in};
                            r_rd_stb  <= 1'b1;
                            r_low     <= 1'b0;
                            r_left    <= r_left - 13'd1;
                            if (r_left == 13'd1) begin
                                r_state <= RD_CRC;
                                r_cnt   <= 4'd15;
                            end
                        end
                    end
                    RD_CRC: begin
                        r_bad <= r_bad | (i_sdio_data_in != w_crc_msb);
                        r_crc <= w_crc_shl;
                        if (r_cnt == 4'd0) r_state <= RD_END;
                        else r_cnt <= r_cnt - 4'd1;
                    end
                    RD_END: begin
                        r_state    <= FINISHED;
                        r_finished <= 1'b1;
                        if (r_bad || i_sdio_data_in != 4'hF) r_crc_err <= 1'b1;
                    end
                    FINISHED: begin
                        r_finished <= 1'b1;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_wr_ready      = r_wr_ready;
    assign o_rd_data       = r_rd_data;
    assign o_rd_stb        = r_rd_stb;
    assign o_finished      = r_finished;
    assign o_crc_err       = r_crc_err;
    assign o_timeout       = r_timeout;
    assign o_underrun      = r_underrun;
    assign o_busy          = r_busy;
    assign o_sdio_data_dir = r_dir;
    assign o_sdio_data_out = r_out;

endmodule

// File: tb/tb_sdio_host_data_phy.sv
// tb_sdio_host_data_phy: scoreboard bench with a small SDIO card model
// for writes (CRC status, busy) and reads (data plus per-line CRC).
module tb_sdio_host_data_phy;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_activate;
    logic        i_write_flag;
    logic [12:0] i_data_count;
    logic [7:0]  i_wr_data;
    logic        i_wr_valid;
    logic        o_wr_ready;
    logic [7:0]  o_rd_data;
    logic        o_rd_stb;
    logic        o_finished;
    logic        o_crc_err;
    logic        o_timeout;
    logic        o_underrun;
    logic        o_busy;
    logic        o_sdio_data_dir;
    logic [3:0]  o_sdio_data_out;
    logic [3:0]  i_sdio_data_in;

    always #5 clk = ~clk;

    sdio_host_data_phy #(.TIMEOUT_CYCLES(16'd16)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_activate      (i_activate),
        .i_write_flag    (i_write_flag),
        .i_data_count    (i_data_count),
        .i_wr_data       (i_wr_data),
        .i_wr_valid      (i_wr_valid),
        .o_wr_ready      (o_wr_ready),
        .o_rd_data       (o_rd_data),
        .o_rd_stb        (o_rd_stb),
        .o_finished      (o_finished),
        .o_crc_err       (o_crc_err),
        .o_timeout       (o_timeout),
        .o_underrun      (o_underrun),
        .o_busy          (o_busy),
        .o_sdio_data_dir (o_sdio_data_dir),
        .o_sdio_data_out (o_sdio_data_out),
        .i_sdio_data_in  (i_sdio_data_in)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         strobes = 0;
    bit         mon_en = 1'b0;
    logic [3:0] bus_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] wb[0:3];
    logic [7:0] rb[0:511];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        crc_bit = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    always @(negedge clk) begin
        if (mon_en && o_sdio_data_dir) begin
            if (bus_q.size() == 0) chk("bus_extra", 32'(bus_q.size()), 32'd1);
            else chk("bus_nibble", o_sdio_data_out, bus_q.pop_front());
        end
        if (o_rd_stb) begin
            strobes++;
            if (rd_q.size() == 0) chk("rd_extra", 32'(rd_q.size()), 32'd1);
            else chk("rd_data", o_rd_data, rd_q.pop_front());
        end
    end

    task automatic release_bus();
        i_activate = 1'b0;
        i_wr_valid = 1'b0;
        i_sdio_data_in = 4'hF;
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        chk("released_fin", o_finished, 1'b0);
    endtask

    task automatic do_write(input int n, input logic [2:0] stat,
                            input int busy_n, input int urun,
                            output int busy_cnt);
        logic [15:0] c[4];
        logic [3:0]  v;
        int ph;
        int bi;
        logic prev_dir;
        logic dat0;
        for (int i = 0; i < 4; i++) c[i] = 16'h0;
        bus_q.delete();
        bus_q.push_back(4'h0);
        for (int k = 0; k < n; k++) begin
            if (k == urun) break;
            bus_q.push_back(wb[k][7:4]);
            bus_q.push_back(wb[k][3:0]);
            for (int i = 0; i < 4; i++) c[i] = crc_bit(c[i], wb[k][4+i]);
            for (int i = 0; i < 4; i++) c[i] = crc_bit(c[i], wb[k][i]);
        end
        if (urun < 0) begin
            for (int j = 15; j >= 0; j--) begin
                v = {c[3][j], c[2][j], c[1][j], c[0][j]};
                bus_q.push_back(v);
            end
            bus_q.push_back(4'hF);
        end
        busy_cnt = 0;
        ph = -1;
        bi = 0;
        prev_dir = 1'b0;
        i_write_flag = 1'b1;
        i_data_count = 13'(n);
        mon_en = 1'b1;
        i_activate = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (o_busy) busy_cnt++;
            if (o_finished) break;
            if (o_wr_ready) begin
                i_wr_data = (bi < 4) ? wb[bi] : 8'h00;
                i_wr_valid = (bi != urun) && (bi < n);
                bi++;
            end else begin
                i_wr_valid = 1'b0;
            end
            if (ph < 0) begin
                if (prev_dir && !o_sdio_data_dir) ph = 0;
            end else begin
                ph++;
            end
            prev_dir = o_sdio_data_dir;
            dat0 = 1'b1;
            if (ph == 4) dat0 = 1'b0;
            else if (ph >= 5 && ph <= 7) dat0 = stat[7-ph];
            else if (ph >= 9 && ph < 9 + busy_n) dat0 = 1'b0;
            i_sdio_data_in = {3'b111, dat0};
        end
        chk("wr_finished", o_finished, 1'b1);
        chk("wr_bus_left", 32'(bus_q.size()), 32'd0);
    endtask

    task automatic do_read(input int n, input bit flip, input int rst_at);
        logic [15:0] c[4];
        logic [3:0]  seq[0:1099];
        logic [3:0]  v;
        int L;
        for (int i = 0; i < 4; i++) c[i] = 16'h0;
        for (int k = 0; k < 3; k++) seq[k] = 4'hF;
        seq[3] = 4'h0;
        L = 4;
        for (int k = 0; k < n; k++) begin
            seq[L] = rb[k][7:4];
            seq[L+1] = rb[k][3:0];
            L += 2;
            for (int i = 0; i < 4; i++) c[i] = crc_bit(c[i], rb[k][4+i]);
            for (int i = 0; i < 4; i++) c[i] = crc_bit(c[i], rb[k][i]);
        end
        for (int j = 15; j >= 0; j--) begin
            v = {c[3][j], c[2][j], c[1][j], c[0][j]};
            if (flip && j == 10) v[2] = ~v[2];
            seq[L] = v;
            L++;
        end
        seq[L] = 4'hF;
        L++;
        rd_q.delete();
        strobes = 0;
        i_write_flag = 1'b0;
        i_data_count = 13'(n);
        i_sdio_data_in = 4'hF;
        i_activate = 1'b1;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            @(negedge clk);
            if (o_finished) break;
            if (cyc == 0) i_data_count = 13'd3;
            i_sdio_data_in = (cyc < L) ? seq[cyc] : 4'hF;
            if (cyc >= 4 && cyc < 4 + 2 * n && ((cyc - 4) % 2) == 0)
                rd_q.push_back(rb[(cyc-4)/2]);
            if (cyc == rst_at) begin
                rst = 1'b0;
                #1;
                chk("rst_dir", o_sdio_data_dir, 1'b0);
                chk("rst_out", o_sdio_data_out, 4'hF);
                chk("rst_rd_data", o_rd_data, 8'h00);
                chk("rst_rd_stb", o_rd_stb, 1'b0);
                chk("rst_fin", o_finished, 1'b0);
                i_activate = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                rd_q.delete();
                return;
            end
        end
        chk("rd_finished", o_finished, 1'b1);
        chk("rd_strobes", 32'(strobes), 32'(n));
        chk("rd_timeout", o_timeout, 1'b0);
    endtask

    initial begin
        int busy_cnt;
        int cyc;
        i_activate = 1'b0;
        i_write_flag = 1'b0;
        i_data_count = '0;
        i_wr_data = '0;
        i_wr_valid = 1'b0;
        i_sdio_data_in = 4'hF;
        #1 rst = 1'b0;
        #2;
        chk("reset_dir", o_sdio_data_dir, 1'b0);
        chk("reset_out", o_sdio_data_out, 4'hF);
        chk("reset_flags", {o_finished, o_crc_err, o_timeout, o_underrun, o_busy}, 5'b0);
        chk("reset_strobes", {o_wr_ready, o_rd_stb}, 2'b0);
        chk("reset_rd_data", o_rd_data, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        wb[0] = 8'hA5; wb[1] = 8'h3C; wb[2] = 8'h00; wb[3] = 8'h00;
        do_write(2, 3'b010, 5, -1, busy_cnt);
        chk("w_good_busy", 32'(busy_cnt), 32'd5);
        chk("w_good_err", {o_crc_err, o_timeout, o_underrun}, 3'b000);
        release_bus();

        wb[0] = 8'h5A; wb[1] = 8'hFF; wb[2] = 8'h01;
        do_write(3, 3'b101, 5, -1, busy_cnt);
        chk("w_bad_crc_err", o_crc_err, 1'b1);
        chk("w_bad_busy", 32'(busy_cnt), 32'd0);
        release_bus();

        for (int k = 0; k < 512; k++) rb[k] = 8'($urandom);
        do_read(512, 1'b0, -1);
        chk("rd_good_crc", o_crc_err, 1'b0);
        release_bus();

        do_read(512, 1'b1, -1);
        chk("rd_flip_crc", o_crc_err, 1'b1);
        release_bus();

        i_write_flag = 1'b0;
        i_data_count = 13'd4;
        i_sdio_data_in = 4'hF;
        i_activate = 1'b1;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (o_finished) break;
        end
        chk("tmo_cycles", 32'(cyc), 32'd17);
        chk("tmo_flag", o_timeout, 1'b1);
        chk("tmo_crc", o_crc_err, 1'b0);
        release_bus();

        wb[0] = 8'hA5; wb[1] = 8'h3C; wb[2] = 8'h77;
        do_write(3, 3'b010, 0, 1, busy_cnt);
        chk("urun_flag", o_underrun, 1'b1);
        chk("urun_tmo_clr", o_timeout, 1'b0);
        chk("urun_dir", o_sdio_data_dir, 1'b0);
        chk("urun_out", o_sdio_data_out, 4'hF);
        release_bus();

        i_write_flag = 1'b1;
        i_data_count = 13'd4;
        i_wr_data = 8'h11;
        i_wr_valid = 1'b1;
        i_activate = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_drive", o_sdio_data_dir, 1'b1);
        i_activate = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_dir", o_sdio_data_dir, 1'b0);
        chk("abort_out", o_sdio_data_out, 4'hF);
        chk("abort_ready", o_wr_ready, 1'b0);
        chk("abort_fin", o_finished, 1'b0);
        i_wr_valid = 1'b0;
        @(negedge clk);

        i_write_flag = 1'b1;
        i_data_count = 13'd0;
        i_activate = 1'b1;
        @(posedge clk);
        #1;
        chk("zero_fin", o_finished, 1'b1);
        chk("zero_dir", o_sdio_data_dir, 1'b0);
        release_bus();

        do_read(16, 1'b0, 20);
        @(negedge clk);
        chk("post_rst_fin", o_finished, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
